plug_board_bank: RTL and testbench
==================================

// Module: plug_board_bank
// PURPOSE
//  Parametrised plugboard: holds up to NUM_PAIRS letter pairs, loaded one letter per LD strobe.
//  Each pair becomes active once both of its letters are stored.
//  Substitutes a letter stream through the active pairs; letters not in any pair pass through.
//  Sits between the keyboard encoder and the rotor stack; the same instance serves the forward and return paths.
// PARAMETERS
//  NUM_PAIRS  10  max simultaneously active pairs (1..13)
//  ALPHA      26  alphabet size; legal letters are 0..ALPHA-1
//  LW         5   letter width; must satisfy 2**LW >= ALPHA
// PORTS
//  CLK        in   1              system clock, all logic on posedge
//  RST        in   1              synchronous reset, active-high
//  LD         in   1              load strobe (1-cycle), qualifies LET
//  LET        in   LW             letter being loaded
//  CLR        in   1              synchronous clear of all pairs and any held letter
//  IN_VALID   in   1              substitution request
//  IN_LET     in   LW             letter to substitute
//  OUT_VALID  out  1              substitution result valid
//  OUT_LET    out  LW             substituted letter
//  PAIRS      out  $clog2(NUM_PAIRS+1)  count of active pairs
//  HOLDING    out  1              first letter of a pair is held, waiting for its partner
//  ERR        out  1              1-cycle pulse: last LD was rejected
// BEHAVIOUR
//  Reset (RST=1): all slots inactive, held letter cleared, state EMPTY.
//   Outputs: OUT_VALID=0, OUT_LET=0, PAIRS=0, HOLDING=0, ERR=0. RST has priority over CLR, LD and IN_VALID.
//  FSM states: EMPTY, HOLD, FULL.
//   EMPTY + LD with a good letter -> latch letter, go to HOLD (HOLDING=1).
//   HOLD + LD with a good letter != held letter -> write pair into the lowest free slot; PAIRS+1.
//     Next state: FULL if PAIRS reaches NUM_PAIRS, else EMPTY.
//   HOLD + LD with LET == held letter -> ERR; held letter dropped; go to EMPTY.
//   FULL + LD -> ERR; no state change.
//  Letter is bad if LET >= ALPHA -> ERR; state and slots unchanged (HOLD stays HOLD).
//  CLR: next cycle all slots inactive, PAIRS=0, state EMPTY. CLR beats an LD in the same cycle.
//  ERR is registered: it is asserted the cycle after the offending LD.
//  Lookup latency is one cycle: OUT_VALID = IN_VALID delayed by one.
//   OUT_LET = partner of IN_LET if IN_LET is in an active slot, else IN_LET.
//   OUT_LET holds its value when OUT_VALID=0.
//  Same-cycle LD and IN_VALID: the lookup uses the slot contents from before the edge.
//   A pair completed by that LD is visible to lookups issued from the next cycle on.
//  A held (incomplete) letter never affects lookup.
//  IN_LET >= ALPHA passes through unchanged.
// CONFIGURATION
//  PLUG_DUP_CHECK_EN defined:
//   An LD whose letter is already in an active slot is rejected with ERR, same as a bad letter.
//   Every letter is therefore in at most one pair.
//  PLUG_DUP_CHECK_EN undefined:
//   Such letters are accepted.
//   Lookup resolves to the lowest-index matching slot (priority encode from slot 0).
// STRUCTURE
//  Package plug_pkg holds:
//   - typedef enum logic [1:0] {EMPTY, HOLD, FULL} plug_state_t
//   - typedef logic [LW-1:0] letter_t
//   - localparam ALPHA_DEF=26
//  Sub-module plug_pair_slot: one slot, NUM_PAIRS instances.
//   Ports: CLK, RST, CLR, WE, A, B, QUERY -> ACTIVE, HIT, PARTNER.
//   Registers: active bit plus letters A and B.
//   Combinational: HIT and PARTNER compare against QUERY.
//  The top level holds the FSM, the free-slot priority encoder, the PAIRS counter and the result mux.
// TESTING
//  1. Reset, LD 3 then LD 7; IN_LET=3 -> OUT_LET=7 one cycle later, IN_LET=7 -> 3, IN_LET=4 -> 4; PAIRS=1.
//  2. LD 5 then LD 5 -> ERR pulse, HOLDING=0, PAIRS unchanged; LD 30 (ALPHA=26) -> ERR, state unchanged.
//  3. Load NUM_PAIRS disjoint pairs -> PAIRS=NUM_PAIRS; next LD -> ERR; CLR -> PAIRS=0, all letters pass through.
//  4. Complete pair (2,9) with IN_VALID=1, IN_LET=2 in the same cycle -> OUT_LET=2; repeat next cycle -> 9.
//  5. Assert RST while in HOLD with 3 active pairs -> next cycle PAIRS=0, HOLDING=0, OUT_VALID=0.
//  6. Load (1,4) then (1,6):
//     with PLUG_DUP_CHECK_EN, LD 1 -> ERR and IN_LET=1 -> 4;
//     without it, PAIRS=2, IN_LET=1 -> 4, IN_LET=6 -> 1.

Source files
------------

// File: rtl/plug_pkg.sv
// Shared types and defaults for the plugboard bank.
package plug_pkg;

  localparam int ALPHA_DEF     = 26;
  localparam int LW_DEF        = 5;
  localparam int NUM_PAIRS_DEF = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FULL  = 2'd2
  } plug_state_t;

  typedef logic [LW_DEF-1:0] letter_t;

endpackage : plug_pkg

// File: rtl/plug_pair_slot.sv
// One plugboard slot: stores a letter pair and answers lookups against it.
// HIT/PARTNER serve the substitution path; DUP_HIT reports whether the letter
// currently being loaded is already plugged into this slot.
module plug_pair_slot
  import plug_pkg::*;
#(
  parameter int LW = LW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  input  logic          WE,
  input  logic [LW-1:0] A,
  input  logic [LW-1:0] B,
  input  logic [LW-1:0] QUERY,
  input  logic [LW-1:0] DUP_QUERY,
  output logic          ACTIVE,
  output logic          HIT,
  output logic [LW-1:0] PARTNER,
  output logic          DUP_HIT
);

  logic          active_q;
  logic [LW-1:0] a_q;
  logic [LW-1:0] b_q;

  // Active flag: cleared by reset or clear, set when the pair is written.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      active_q <= 1'b0;
    end else if (WE) begin
      active_q <= 1'b1;
    end
  end

  // Letter storage: only meaningful while active, so it is left out of reset.
  // NOTE: data registers gated by a valid bit need no reset; only the valid bit does.
  always_ff @(posedge CLK) begin
    if (WE) begin
      a_q <= A;
      b_q <= B;
    end
  end

  // Lookup and duplicate compare against the stored pair.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    HIT     = 1'b0;
    PARTNER = a_q;
    DUP_HIT = 1'b0;
    if (active_q) begin
      HIT     = (QUERY == a_q) || (QUERY == b_q);
      PARTNER = (QUERY == a_q) ? b_q : a_q;
      DUP_HIT = (DUP_QUERY == a_q) || (DUP_QUERY == b_q);
    end
  end

  assign ACTIVE = active_q;

endmodule : plug_pair_slot

// File: rtl/plug_board_bank.sv
// Plugboard bank: loads letter pairs one letter per LD strobe into NUM_PAIRS
// slots and substitutes a letter stream through the active pairs with one
// cycle of latency.
// Build option: define PLUG_DUP_CHECK_EN to reject loading a letter that is
// already part of an active pair (each letter then sits in at most one pair).
module plug_board_bank
  import plug_pkg::*;
#(
  parameter int NUM_PAIRS = NUM_PAIRS_DEF,
  parameter int ALPHA     = ALPHA_DEF,
  parameter int LW        = LW_DEF
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           LD,
  input  logic [LW-1:0]                  LET,
  input  logic                           CLR,
  input  logic                           IN_VALID,
  input  logic [LW-1:0]                  IN_LET,
  output logic                           OUT_VALID,
  output logic [LW-1:0]                  OUT_LET,
  output logic [$clog2(NUM_PAIRS+1)-1:0] PAIRS,
  output logic                           HOLDING,
  output logic                           ERR
);

  localparam int PW = $clog2(NUM_PAIRS + 1);

`ifdef PLUG_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  plug_state_t   state_q, state_d;
  logic [LW-1:0] held_q, held_d;
  logic [PW-1:0] pairs_q, pairs_d;
  logic          err_q, err_d;
  logic          out_valid_q;
  logic [LW-1:0] out_let_q;

  logic [NUM_PAIRS-1:0] slot_active;
  logic [NUM_PAIRS-1:0] slot_hit;
  logic [NUM_PAIRS-1:0] slot_dup;
  logic [NUM_PAIRS-1:0] slot_we;
  logic [NUM_PAIRS-1:0] free_onehot;
  logic [LW-1:0]        slot_partner [NUM_PAIRS];

  logic          write_pair;
  logic          let_good;
  logic [LW-1:0] lookup_let;

  // Slot array; a pair is written as (held letter, current letter).
  for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_slot
    plug_pair_slot #(.LW(LW)) u_slot (
      .CLK       (CLK),
      .RST       (RST),
      .CLR       (CLR),
      .WE        (slot_we[i]),
      .A         (held_q),
      .B         (LET),
      .QUERY     (IN_LET),
      .DUP_QUERY (LET),
      .ACTIVE    (slot_active[i]),
      .HIT       (slot_hit[i]),
      .PARTNER   (slot_partner[i]),
      .DUP_HIT   (slot_dup[i])
    );
  end

  // Lowest free slot (lowest zero bit of the active vector) gets the next pair.
  always_comb begin
    free_onehot = ~slot_active & (slot_active + NUM_PAIRS'(1));
    slot_we     = write_pair ? free_onehot : '0;
  end

  // A loaded letter is usable if in range and, with duplicate checking, not already plugged.
  always_comb begin
    let_good = (int'(LET) < ALPHA) && !(DUP_EN && (|slot_dup));
  end

  // Lookup result: lowest-index matching slot wins, otherwise pass through.
  always_comb begin
    lookup_let = IN_LET;
    for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
      if (slot_hit[i]) lookup_let = slot_partner[i];
    end
  end

  // Load FSM next-state: clear beats load; a rejected letter changes nothing but ERR.
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    pairs_d    = pairs_q;
    err_d      = 1'b0;
    write_pair = 1'b0;
    if (CLR) begin
      state_d = EMPTY;
      held_d  = '0;
      pairs_d = '0;
    end else if (LD) begin
      if (!let_good) begin
        err_d = 1'b1;
      end else begin
        unique case (state_q)
          EMPTY: begin
            held_d  = LET;
            state_d = HOLD;
          end
          HOLD: begin
            held_d = '0;
            if (LET == held_q) begin
              err_d   = 1'b1;
              state_d = EMPTY;
            end else begin
              write_pair = 1'b1;
              pairs_d    = pairs_q + PW'(1);
              state_d    = (pairs_q == PW'(NUM_PAIRS - 1)) ? FULL : EMPTY;
            end
          end
          FULL:    err_d   = 1'b1;
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  // FSM, counter and error registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      held_q  <= '0;
      pairs_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      pairs_q <= pairs_d;
      err_q   <= err_d;
    end
  end

  // Substitution pipeline stage; the result holds while no request arrives.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_let_q   <= '0;
    end else begin
      out_valid_q <= IN_VALID;
      if (IN_VALID) out_let_q <= lookup_let;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_LET   = out_let_q;
  assign PAIRS     = pairs_q;
  assign HOLDING   = (state_q == HOLD);
  assign ERR       = err_q;

endmodule : plug_board_bank

// File: tb/tb_plug_board_bank.sv
// Self-checking bench for plug_board_bank (default parameters).
module tb_plug_board_bank;

  localparam int NP = 10;
  localparam int AL = 26;
  localparam int LW = 5;
  localparam int PW = $clog2(NP + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          LD = 1'b0;
  logic [LW-1:0] LET = '0;
  logic          CLR = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [LW-1:0] IN_LET = '0;
  logic          OUT_VALID;
  logic [LW-1:0] OUT_LET;
  logic [PW-1:0] PAIRS;
  logic          HOLDING;
  logic          ERR;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of completed pairs plus a held letter.
  int q_a[$];
  int q_b[$];
  int m_held;
  bit m_holding;
  bit m_out_valid;
  int m_out_let;
  bit m_err;

  plug_board_bank #(.NUM_PAIRS(NP), .ALPHA(AL), .LW(LW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LD        (LD),
    .LET       (LET),
    .CLR       (CLR),
    .IN_VALID  (IN_VALID),
    .IN_LET    (IN_LET),
    .OUT_VALID (OUT_VALID),
    .OUT_LET   (OUT_LET),
    .PAIRS     (PAIRS),
    .HOLDING   (HOLDING),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    m_held      = 0;
    m_holding   = 1'b0;
    m_out_valid = 1'b0;
    m_out_let   = 0;
    m_err       = 1'b0;
  endtask

  function automatic int model_lookup(input int l);
    for (int i = 0; i < q_a.size(); i++) begin
      if (q_a[i] == l) return q_b[i];
      if (q_b[i] == l) return q_a[i];
    end
    return l;
  endfunction

  task automatic model_step(input bit ld, input int l, input bit clr, input bit iv, input int il);
    bit good;
    if (iv) m_out_let = model_lookup(il);
    m_out_valid = iv;
    m_err       = 1'b0;
    if (clr) begin
      q_a.delete();
      q_b.delete();
      m_holding = 1'b0;
    end else if (ld) begin
      good = (l < AL);
`ifdef PLUG_DUP_CHECK_EN
      for (int i = 0; i < q_a.size(); i++)
        if (q_a[i] == l || q_b[i] == l) good = 1'b0;
`endif
      if (!good || q_a.size() == NP) begin
        m_err = 1'b1;
      end else if (!m_holding) begin
        m_held    = l;
        m_holding = 1'b1;
      end else if (l == m_held) begin
        m_err     = 1'b1;
        m_holding = 1'b0;
      end else begin
        q_a.push_back(m_held);
        q_b.push_back(l);
        m_holding = 1'b0;
      end
    end
  endtask

  // Apply one cycle of stimulus, advance the model, and return #1 after the edge.
  task automatic drive(input bit ld, input int l, input bit clr, input bit iv, input int il);
    LD       = ld;
    LET      = LW'(l);
    CLR      = clr;
    IN_VALID = iv;
    IN_LET   = LW'(il);
    model_step(ld, l, clr, iv, il);
    @(posedge CLK);
    #1;
    LD       = 1'b0;
    CLR      = 1'b0;
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    LD  = 1'b1;
    LET = 5'd4;
    IN_VALID = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    LD  = 1'b0;
    IN_VALID = 1'b0;
    model_reset();
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", OUT_VALID); end
    total++; if (OUT_LET !== '0) begin bad++; $display("FAIL reset_out_let got=%0d want=0", OUT_LET); end
    total++; if (PAIRS !== '0) begin bad++; $display("FAIL reset_pairs got=%0d want=0", PAIRS); end
    total++; if (HOLDING !== 1'b0) begin bad++; $display("FAIL reset_holding got=%b want=0", HOLDING); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", ERR); end
  endtask

  task automatic test_basic_pair();
    drive(1, 3, 0, 0, 0);
    total++; if (HOLDING !== 1'b1) begin bad++; $display("FAIL basic_holding got=%b want=1", HOLDING); end
    drive(1, 7, 0, 0, 0);
    total++; if (PAIRS !== PW'(1)) begin bad++; $display("FAIL basic_pairs got=%0d want=1", PAIRS); end
    total++; if (HOLDING !== 1'b0) begin bad++; $display("FAIL basic_hold_drop got=%b want=0", HOLDING); end
    drive(0, 0, 0, 1, 3);
    total++; if (OUT_VALID !== 1'b1 || OUT_LET !== 5'd7) begin bad++; $display("FAIL basic_3to7 got=%b/%0d want=1/7", OUT_VALID, OUT_LET); end
    drive(0, 0, 0, 1, 7);
    total++; if (OUT_LET !== 5'd3) begin bad++; $display("FAIL basic_7to3 got=%0d want=3", OUT_LET); end
    drive(0, 0, 0, 1, 4);
    total++; if (OUT_LET !== 5'd4) begin bad++; $display("FAIL basic_4pass got=%0d want=4", OUT_LET); end
    drive(0, 0, 0, 0, 9);
    total++; if (OUT_VALID !== 1'b0 || OUT_LET !== 5'd4) begin bad++; $display("FAIL basic_hold_out got=%b/%0d want=0/4", OUT_VALID, OUT_LET); end
  endtask

  task automatic test_errors();
    drive(1, 5, 0, 0, 0);
    drive(1, 5, 0, 0, 0);
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL same_letter_err got=%b want=1", ERR); end
    total++; if (HOLDING !== 1'b0) begin bad++; $display("FAIL same_letter_holding got=%b want=0", HOLDING); end
    total++; if (PAIRS !== PW'(1)) begin bad++; $display("FAIL same_letter_pairs got=%0d want=1", PAIRS); end
    drive(0, 0, 0, 0, 0);
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b want=0", ERR); end
    drive(1, 8, 0, 0, 0);
    drive(1, 30, 0, 0, 0);
    total++; if (ERR !== 1'b1 || HOLDING !== 1'b1) begin bad++; $display("FAIL bad_letter got err=%b hold=%b want err=1 hold=1", ERR, HOLDING); end
    drive(1, 9, 0, 0, 0);
    total++; if (PAIRS !== PW'(2) || ERR !== 1'b0) begin bad++; $display("FAIL after_bad_pair got pairs=%0d err=%b want 2/0", PAIRS, ERR); end
  endtask

  task automatic test_full_and_clear();
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < NP; i++) begin
      drive(1, 2 * i, 0, 0, 0);
      drive(1, 2 * i + 1, 0, 0, 0);
    end
    total++; if (PAIRS !== PW'(NP)) begin bad++; $display("FAIL full_pairs got=%0d want=%0d", PAIRS, NP); end
    drive(0, 0, 0, 1, 19);
    total++; if (OUT_LET !== 5'd18) begin bad++; $display("FAIL full_last_pair got=%0d want=18", OUT_LET); end
    drive(1, 20, 0, 0, 0);
    total++; if (ERR !== 1'b1 || PAIRS !== PW'(NP)) begin bad++; $display("FAIL full_reject got err=%b pairs=%0d want 1/%0d", ERR, PAIRS, NP); end
    drive(1, 21, 1, 0, 0);
    total++; if (PAIRS !== '0 || ERR !== 1'b0 || HOLDING !== 1'b0) begin bad++; $display("FAIL clear got pairs=%0d err=%b hold=%b want 0/0/0", PAIRS, ERR, HOLDING); end
    for (int l = 0; l < AL; l++) begin
      drive(0, 0, 0, 1, l);
      total++; if (OUT_LET !== LW'(l)) begin bad++; $display("FAIL clear_pass letter=%0d got=%0d want=%0d", l, OUT_LET, l); end
    end
  endtask

  task automatic test_same_cycle();
    drive(0, 0, 1, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(1, 9, 0, 1, 2);
    total++; if (OUT_LET !== 5'd2) begin bad++; $display("FAIL same_cycle_old got=%0d want=2", OUT_LET); end
    drive(0, 0, 0, 1, 2);
    total++; if (OUT_LET !== 5'd9) begin bad++; $display("FAIL same_cycle_new got=%0d want=9", OUT_LET); end
    drive(1, 6, 0, 0, 0);
    drive(0, 0, 0, 1, 6);
    total++; if (OUT_LET !== 5'd6) begin bad++; $display("FAIL held_no_lookup got=%0d want=6", OUT_LET); end
    drive(0, 0, 0, 1, 31);
    total++; if (OUT_LET !== 5'd31) begin bad++; $display("FAIL out_of_range_pass got=%0d want=31", OUT_LET); end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 10 + 2 * i, 0, 0, 0);
      drive(1, 11 + 2 * i, 0, 0, 0);
    end
    drive(1, 16, 0, 1, 10);
    total++; if (HOLDING !== 1'b1 || PAIRS !== PW'(3)) begin bad++; $display("FAIL pre_rst got hold=%b pairs=%0d want 1/3", HOLDING, PAIRS); end
    RST = 1'b1; LD = 1'b1; LET = 5'd17; CLR = 1'b1; IN_VALID = 1'b1; IN_LET = 5'd10;
    @(posedge CLK);
    #1;
    RST = 1'b0; LD = 1'b0; CLR = 1'b0; IN_VALID = 1'b0;
    model_reset();
    total++; if (PAIRS !== '0 || HOLDING !== 1'b0 || OUT_VALID !== 1'b0 || ERR !== 1'b0) begin
      bad++; $display("FAIL rst_mid got pairs=%0d hold=%b ov=%b err=%b want 0/0/0/0", PAIRS, HOLDING, OUT_VALID, ERR);
    end
    drive(0, 0, 0, 1, 10);
    total++; if (OUT_LET !== 5'd10) begin bad++; $display("FAIL rst_slots_cleared got=%0d want=10", OUT_LET); end
  endtask

  task automatic test_dup();
    drive(0, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 4, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
`ifdef PLUG_DUP_CHECK_EN
    total++; if (ERR !== 1'b1 || HOLDING !== 1'b0) begin bad++; $display("FAIL dup_reject got err=%b hold=%b want 1/0", ERR, HOLDING); end
`else
    total++; if (ERR !== 1'b0 || HOLDING !== 1'b1) begin bad++; $display("FAIL dup_accept got err=%b hold=%b want 0/1", ERR, HOLDING); end
`endif
    drive(1, 6, 0, 0, 0);
`ifdef PLUG_DUP_CHECK_EN
    total++; if (PAIRS !== PW'(1)) begin bad++; $display("FAIL dup_pairs got=%0d want=1", PAIRS); end
`else
    total++; if (PAIRS !== PW'(2)) begin bad++; $display("FAIL dup_pairs got=%0d want=2", PAIRS); end
    drive(0, 0, 0, 1, 6);
    total++; if (OUT_LET !== 5'd1) begin bad++; $display("FAIL dup_6to1 got=%0d want=1", OUT_LET); end
`endif
    drive(0, 0, 0, 1, 1);
    total++; if (OUT_LET !== 5'd4) begin bad++; $display("FAIL dup_1to4 got=%0d want=4", OUT_LET); end
  endtask

  // Random load/clear/lookup traffic compared every cycle against the model.
  task automatic test_back_to_back();
    bit ld, clr, iv;
    int l, il;
    drive(0, 0, 1, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      ld  = ($urandom_range(0, 99) < 55);
      clr = ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 99) < 60);
      l   = ($urandom_range(0, 19) == 0) ? $urandom_range(AL, 31) : $urandom_range(0, AL - 1);
      il  = $urandom_range(0, 31);
      drive(ld, l, clr, iv, il);
      total++; if (OUT_VALID !== m_out_valid) begin bad++; $display("FAIL rnd_out_valid n=%0d got=%b want=%b", n, OUT_VALID, m_out_valid); end
      total++; if (OUT_LET !== LW'(m_out_let)) begin bad++; $display("FAIL rnd_out_let n=%0d got=%0d want=%0d", n, OUT_LET, m_out_let); end
      total++; if (PAIRS !== PW'(q_a.size())) begin bad++; $display("FAIL rnd_pairs n=%0d got=%0d want=%0d", n, PAIRS, q_a.size()); end
      total++; if (HOLDING !== m_holding) begin bad++; $display("FAIL rnd_holding n=%0d got=%b want=%b", n, HOLDING, m_holding); end
      total++; if (ERR !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%b want=%b", n, ERR, m_err); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_pair();
    test_errors();
    test_full_and_clear();
    test_same_cycle();
    test_reset_mid();
    test_dup();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_plug_board_bank
